// File: rtl/pipe_phy_pkg.sv
// Shared definitions for the behavioural PIPE PHY responder.
//   - power-state encodings carried on PowerDown / CurrentPowerDown
//   - per-lane RxStatus codes returned on receiver detect
//   - FSM state encoding used by pipe_phy_responder
package pipe_phy_pkg;

  localparam logic [3:0] P0  = 4'd0;
  localparam logic [3:0] P0S = 4'd1;
  localparam logic [3:0] P1  = 4'd2;
  localparam logic [3:0] P2  = 4'd3;

  localparam logic [2:0] RXSTAT_OK       = 3'b000;
  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  typedef logic [2:0] phy_state_t;

  localparam phy_state_t ST_RESET_WAIT  = 3'd0;
  localparam phy_state_t ST_IDLE        = 3'd1;
  localparam phy_state_t ST_PD_BUSY     = 3'd2;
  localparam phy_state_t ST_RATE_BUSY   = 3'd3;
  localparam phy_state_t ST_DET_BUSY    = 3'd4;
  localparam phy_state_t ST_DET_RELEASE = 3'd5;

  // Encodings above P2 are not real power states and never cause a transition.
  function automatic logic pd_valid(input logic [3:0] pd);
    return pd <= P2;
  endfunction

  // Receiver only sees the far end in the active states.
  function automatic logic pd_active(input logic [3:0] pd);
    return (pd == P0) || (pd == P0S);
  endfunction

endpackage

// File: rtl/phy_latency_counter.sv
// 8-bit load/decrement counter shared by every timed state of the responder.
//   clk        : clock
//   rst_n      : asynchronous active-low reset (count clears to 0)
//   load       : load load_value this cycle (takes priority over decrement)
//   load_value : value to load
//   done       : count is 1, i.e. the next edge is the completion edge
//   empty      : count is 0 (nothing in flight)
module phy_latency_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       done,
  output logic       empty
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  // Loading LAT at edge T makes done true before edge T+LAT.
  assign done  = (count == 8'd1);
  assign empty = (count == 8'd0);

endmodule

// File: rtl/pipe_phy_responder.sv
// Behavioural PHY-side PIPE responder (control path only, no data lanes).
//   CLK, lpreset        : clock, asynchronous active-low reset
//   TxDetectRx_Loopback : receiver-detect request per lane
//   TxElecIdle          : transmitter electrical idle (lane 0 qualifies detect)
//   PowerDown           : requested power state, lane 0 field decoded
//   Rate                : requested rate
//   RxConnected         : far-end receiver present per lane
//   PhyStatus           : reset status / one-cycle completion pulse, all lanes equal
//   RxStatus            : 3-bit status per lane, detect result during the pulse
//   RxElectricalIdle    : receiver idle per lane
//   CurrentPowerDown    : power state in effect
//   CurrentRate         : rate in effect
module pipe_phy_responder
  import pipe_phy_pkg::*;
#(
  parameter int unsigned LANESNUMBER    = 16,
  parameter int unsigned RESET_CYCLES   = 8,
  parameter int unsigned DETECT_LATENCY = 8,
  parameter int unsigned PD_LATENCY     = 4,
  parameter int unsigned RATE_LATENCY   = 16
) (
  input  logic                     CLK,
  input  logic                     lpreset,
  input  logic [LANESNUMBER-1:0]   TxDetectRx_Loopback,
  input  logic [LANESNUMBER-1:0]   TxElecIdle,
  input  logic [4*LANESNUMBER-1:0] PowerDown,
  input  logic [3:0]               Rate,
  input  logic [LANESNUMBER-1:0]   RxConnected,
  output logic [LANESNUMBER-1:0]   PhyStatus,
  output logic [3*LANESNUMBER-1:0] RxStatus,
  output logic [LANESNUMBER-1:0]   RxElectricalIdle,
  output logic [3:0]               CurrentPowerDown,
  output logic [3:0]               CurrentRate
);

  phy_state_t               state_q, state_d;
  logic [LANESNUMBER-1:0]   phy_q, phy_d;
  logic [3*LANESNUMBER-1:0] rx_q, rx_d;
  logic [3:0]               pd_q, pd_d;
  logic [3:0]               rate_q, rate_d;
  logic [3:0]               target_q, target_d;   // PD or rate value captured at acceptance
  logic                     load;
  logic [7:0]               load_value;
  logic                     cnt_done, cnt_empty;

  logic [3:0] pd_req;
  logic       pd_change, rate_change, det_req;
  logic       unused_inputs;

  assign pd_req      = PowerDown[3:0];
  assign pd_change   = pd_valid(pd_req) && (pd_req != pd_q);
  assign rate_change = (Rate != rate_q);
  assign det_req     = (pd_q == P1) && TxElecIdle[0] && (|TxDetectRx_Loopback);
  // Only lane 0 of TxElecIdle / PowerDown is decoded; lanes move together.
  assign unused_inputs = ^{TxElecIdle, PowerDown};

  phy_latency_counter u_counter (
    .clk        (CLK),
    .rst_n      (lpreset),
    .load       (load),
    .load_value (load_value),
    .done       (cnt_done),
    .empty      (cnt_empty)
  );

  always_comb begin
    state_d    = state_q;
    phy_d      = '0;
    rx_d       = '0;
    pd_d       = pd_q;
    rate_d     = rate_q;
    target_d   = target_q;
    load       = 1'b0;
    load_value = 8'd0;
    unique case (state_q)
      ST_RESET_WAIT: begin
        phy_d = '1;
        // Counter is 0 on the first edge after reset: that edge either finishes
        // (RESET_CYCLES == 1) or arms the remaining RESET_CYCLES-1 edges.
        if (cnt_done || (cnt_empty && (RESET_CYCLES == 1))) begin
          phy_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_empty) begin
          load       = 1'b1;
          load_value = 8'(RESET_CYCLES - 1);
        end
      end
      ST_IDLE: begin
        if (pd_change) begin
          target_d   = pd_req;
          load       = 1'b1;
          load_value = 8'(PD_LATENCY);
          state_d    = ST_PD_BUSY;
        end else if (rate_change) begin
          target_d   = Rate;
          load       = 1'b1;
          load_value = 8'(RATE_LATENCY);
          state_d    = ST_RATE_BUSY;
        end else if (det_req) begin
          load       = 1'b1;
          load_value = 8'(DETECT_LATENCY);
          state_d    = ST_DET_BUSY;
        end
      end
      ST_PD_BUSY: begin
        if (cnt_done) begin
          pd_d    = target_q;
          phy_d   = '1;
          state_d = ST_IDLE;
        end
      end
      ST_RATE_BUSY: begin
        if (cnt_done) begin
          rate_d  = target_q;
          phy_d   = '1;
          state_d = ST_IDLE;
        end
      end
      ST_DET_BUSY: begin
        if (cnt_done) begin
          phy_d = '1;
          for (int i = 0; i < LANESNUMBER; i++) begin
            rx_d[3*i +: 3] = RxConnected[i] ? RXSTAT_DETECTED : RXSTAT_OK;
          end
          state_d = ST_DET_RELEASE;
        end
      end
      ST_DET_RELEASE: begin
        // Hold off until the request is withdrawn so one request gives one result.
        if (!(|TxDetectRx_Loopback)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET_WAIT;
    endcase
  end

  always_ff @(posedge CLK or negedge lpreset) begin
    if (!lpreset) begin
      state_q  <= ST_RESET_WAIT;
      phy_q    <= '1;
      rx_q     <= '0;
      pd_q     <= P1;
      rate_q   <= 4'd0;
      target_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      phy_q    <= phy_d;
      rx_q     <= rx_d;
      pd_q     <= pd_d;
      rate_q   <= rate_d;
      target_q <= target_d;
    end
  end

  assign PhyStatus        = phy_q;
  assign RxStatus         = rx_q;
  assign CurrentPowerDown = pd_q;
  assign CurrentRate      = rate_q;
  assign RxElectricalIdle = ~(RxConnected & {LANESNUMBER{pd_active(pd_q)}});

endmodule

// File: tb/tb_pipe_phy_responder.sv
// Self-checking bench for pipe_phy_responder. Inputs change on the falling edge,
// outputs are sampled on the falling edge; a request driven at one falling edge
// is sampled by the next rising edge (edge T), so its pulse is seen LAT+1
// falling edges later.
module tb_pipe_phy_responder;

  localparam int N      = 16;
  localparam int RST_C  = 8;
  localparam int DET_L  = 8;
  localparam int PD_L   = 4;
  localparam int RATE_L = 16;

  logic           CLK = 1'b0;
  logic           lpreset;
  logic [N-1:0]   TxDetectRx_Loopback;
  logic [N-1:0]   TxElecIdle;
  logic [4*N-1:0] PowerDown;
  logic [3:0]     Rate;
  logic [N-1:0]   RxConnected;
  logic [N-1:0]   PhyStatus;
  logic [3*N-1:0] RxStatus;
  logic [N-1:0]   RxElectricalIdle;
  logic [3:0]     CurrentPowerDown;
  logic [3:0]     CurrentRate;

  pipe_phy_responder #(
    .LANESNUMBER    (N),
    .RESET_CYCLES   (RST_C),
    .DETECT_LATENCY (DET_L),
    .PD_LATENCY     (PD_L),
    .RATE_LATENCY   (RATE_L)
  ) dut (
    .CLK                 (CLK),
    .lpreset             (lpreset),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .TxElecIdle          (TxElecIdle),
    .PowerDown           (PowerDown),
    .Rate                (Rate),
    .RxConnected         (RxConnected),
    .PhyStatus           (PhyStatus),
    .RxStatus            (RxStatus),
    .RxElectricalIdle    (RxElectricalIdle),
    .CurrentPowerDown    (CurrentPowerDown),
    .CurrentRate         (CurrentRate)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the PHY should currently report.
  logic [3:0] m_pd;
  logic [3:0] m_rate;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_rxei(input logic [N-1:0] conn, input logic [3:0] pd);
    return (pd < 4'd2) ? ~conn : {N{1'b1}};
  endfunction

  function automatic logic [3*N-1:0] exp_detect(input logic [N-1:0] conn);
    logic [3*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[3*i +: 3] = conn[i] ? 3'b011 : 3'b000;
    return r;
  endfunction

  // Falling edges until PhyStatus[0] is seen high; -1 if the bound expires.
  task automatic wait_pulse(input int limit, output int cycles);
    cycles = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (PhyStatus[0]) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic count_quiet(input int n, output int pulses, output int rx_busy);
    pulses  = 0;
    rx_busy = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (PhyStatus != '0) pulses++;
      if (RxStatus != '0) rx_busy++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_phystatus"}, 64'(PhyStatus), 64'({N{1'b1}}));
    chk({tag, "_rxstatus"}, 64'(RxStatus), 64'd0);
    chk({tag, "_rxei"}, 64'(RxElectricalIdle), 64'({N{1'b1}}));
    chk({tag, "_curpd"}, 64'(CurrentPowerDown), 64'd2);
    chk({tag, "_currate"}, 64'(CurrentRate), 64'd0);
  endtask

  task automatic check_reset_wait(input string tag);
    for (int k = 1; k <= RST_C + 2; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("%s_edge%0d", tag, k), 64'(PhyStatus), (k < RST_C) ? 64'({N{1'b1}}) : 64'd0);
    end
  endtask

  task automatic do_detect(input string tag, input logic [N-1:0] conn, input logic [N-1:0] req);
    int lat, pulses, rxb;
    RxConnected         = conn;
    TxElecIdle          = '1;
    TxDetectRx_Loopback = req;
    wait_pulse(40, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(DET_L + 1));
    chk({tag, "_phystatus"}, 64'(PhyStatus), 64'({N{1'b1}}));
    chk({tag, "_rxstatus"}, 64'(RxStatus), 64'(exp_detect(conn)));
    // Request still held: no second result, status cleared after the pulse.
    count_quiet(20, pulses, rxb);
    chk({tag, "_held_pulses"}, 64'(pulses), 64'd0);
    chk({tag, "_held_rx"}, 64'(rxb), 64'd0);
    TxDetectRx_Loopback = '0;
    @(negedge CLK);
  endtask

  initial begin
    int lat, pulses, rxb;
    logic [3:0] nr;
    lpreset             = 1'b0;
    TxDetectRx_Loopback = '0;
    TxElecIdle          = '1;
    PowerDown           = {N{4'd2}};
    Rate                = 4'd0;
    RxConnected         = 16'h00FF;
    m_pd                = 4'd2;
    m_rate              = 4'd0;

    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    lpreset = 1'b1;
    check_reset_wait("rstwait");

    // Receiver detect in P1, fixed then random lane masks.
    do_detect("det_fixed", 16'h00FF, 16'hFFFF);
    do_detect("det_rand", 16'($urandom()), 16'(1 << $urandom_range(N - 1)));

    // PowerDown P1 -> P0, other lanes' fields must be ignored.
    PowerDown = {48'($urandom()) | 48'h1, 4'd0};
    wait_pulse(40, lat);
    m_pd = 4'd0;
    chk("pd_latency", 64'(lat), 64'(PD_L + 1));
    chk("pd_curpd", 64'(CurrentPowerDown), 64'(m_pd));
    chk("pd_rxei", 64'(RxElectricalIdle), 64'(exp_rxei(RxConnected, m_pd)));
    @(negedge CLK);
    chk("pd_pulse_width", 64'(PhyStatus), 64'd0);
    RxConnected = 16'($urandom());
    #1;
    chk("pd_rxei_rand", 64'(RxElectricalIdle), 64'(exp_rxei(RxConnected, m_pd)));

    // Detect outside P1 is ignored.
    @(negedge CLK);
    TxDetectRx_Loopback = '1;
    count_quiet(DET_L + 10, pulses, rxb);
    chk("det_p0_pulses", 64'(pulses), 64'd0);
    chk("det_p0_rx", 64'(rxb), 64'd0);
    TxDetectRx_Loopback = '0;

    // Invalid power encoding: no change.
    PowerDown[3:0] = 4'(4 + $urandom_range(11));
    count_quiet(PD_L + 6, pulses, rxb);
    chk("pd_invalid_pulses", 64'(pulses), 64'd0);
    chk("pd_invalid_curpd", 64'(CurrentPowerDown), 64'(m_pd));

    // PowerDown and Rate change together: PD first, then Rate after IDLE return.
    PowerDown[3:0] = 4'($urandom_range(1, 3));
    nr = 4'($urandom_range(1, 15));
    Rate = nr;
    wait_pulse(40, lat);
    m_pd = PowerDown[3:0];
    chk("combo_pd_latency", 64'(lat), 64'(PD_L + 1));
    chk("combo_pd_curpd", 64'(CurrentPowerDown), 64'(m_pd));
    chk("combo_pd_rate_unchanged", 64'(CurrentRate), 64'(m_rate));
    wait_pulse(60, lat);
    m_rate = nr;
    chk("combo_rate_latency", 64'(lat), 64'(RATE_L + 1));
    chk("combo_rate_currate", 64'(CurrentRate), 64'(m_rate));
    chk("combo_rate_rxei", 64'(RxElectricalIdle), 64'(exp_rxei(RxConnected, m_pd)));

    // Reset during a rate change discards it.
    @(negedge CLK);
    Rate = m_rate ^ 4'($urandom_range(1, 15));
    repeat (3) @(negedge CLK);
    lpreset = 1'b0;
    #1;
    check_reset_values("midreset");
    Rate           = 4'd0;
    PowerDown[3:0] = 4'd2;
    m_pd           = 4'd2;
    m_rate         = 4'd0;
    @(negedge CLK);
    lpreset = 1'b1;
    check_reset_wait("rstwait2");
    count_quiet(RATE_L + 10, pulses, rxb);
    chk("post_reset_pulses", 64'(pulses), 64'd0);
    chk("post_reset_currate", 64'(CurrentRate), 64'(m_rate));
    chk("post_reset_curpd", 64'(CurrentPowerDown), 64'(m_pd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
